// File: rtl/heap_cmd_pkg.sv
// Shared definitions for the heap priority-queue command issue stage:
// opcodes, FSM state encoding and the queued command record.
package heap_cmd_pkg;

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE
  } state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  op;
    logic [31:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/heap_cmd_fifo.sv
// Synchronous command FIFO with empty flag and occupancy count;
// DEPTH must be a power of two so the pointers wrap naturally.
module heap_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/heap_cmd_issue.sv
// Issue stage for heap push/pop commands: queues core commands, issues them to
// the heap engine one at a time, tracks occupancy. Optional HEAP_CMD_STATS_EN adds counters.
module heap_cmd_issue
  import heap_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HEAP_SIZE  = 256,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_v,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_data,
  output logic        hp_v,
  output logic [2:0]  hp_op,
  output logic [31:0] hp_data,
  input  logic        hp_busy,
  input  logic        hp_done,
  input  logic [31:0] hp_rdata,
  output logic        wb_v,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic [8:0]  occupancy
`ifdef HEAP_CMD_STATS_EN
  ,
  output logic [15:0] stat_push,
  output logic [15:0] stat_pop,
  output logic [15:0] stat_err
`endif
);

  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [8:0] HEAP_MAX = 9'(HEAP_SIZE);

  state_t                      state;
  cmd_t                        head;
  cmd_t                        iss;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        head_reject;
  logic                        deq;
  logic [8:0]                  occ_next;
  logic [TW-1:0]               timer;

  heap_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_v),
    .wdata ({in_rd, in_op, in_data}),
    .pop   (deq),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready = (fifo_count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign hp_op    = iss.op;
  assign hp_data  = iss.data;

  // Rejected heads are dequeued even while the engine is busy; legal ones wait.
  assign head_reject = !op_legal(head.op)
                    || (head.op == OP_POP  && occupancy == '0)
                    || (head.op == OP_PUSH && occupancy == HEAP_MAX);
  assign deq = (state == ST_IDLE) && !fifo_empty && (head_reject || !hp_busy);

  always_comb begin
    occ_next = occupancy;
    if (iss.op == OP_PUSH) begin
      if (occupancy != HEAP_MAX) occ_next = occupancy + 1'b1;
    end else begin
      if (occupancy != '0) occ_next = occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      iss       <= '0;
      timer     <= '0;
      occupancy <= '0;
      hp_v      <= 1'b0;
      wb_v      <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
`ifdef HEAP_CMD_STATS_EN
      stat_push <= '0;
      stat_pop  <= '0;
      stat_err  <= '0;
`endif
    end else begin
      hp_v <= 1'b0;
      wb_v <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (deq) begin
            if (head_reject) begin
              wb_v    <= 1'b1;
              wb_rd   <= head.rd;
              wb_data <= '0;
              wb_err  <= 1'b1;
`ifdef HEAP_CMD_STATS_EN
              stat_err <= stat_err + 1'b1;
`endif
              state   <= ST_RETIRE;
            end else begin
              iss   <= head;
              hp_v  <= 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hp_done) begin
            occupancy <= occ_next;
            wb_v      <= 1'b1;
            wb_rd     <= iss.rd;
            wb_err    <= 1'b0;
            wb_data   <= (iss.op == OP_PUSH) ? {23'b0, occ_next} : hp_rdata;
`ifdef HEAP_CMD_STATS_EN
            if (iss.op == OP_PUSH) stat_push <= stat_push + 1'b1;
            else                   stat_pop  <= stat_pop + 1'b1;
`endif
            state     <= ST_RETIRE;
          end else begin
            timer <= timer + 1'b1;
            if (timer == TW'(TIMEOUT - 1)) begin
              wb_v    <= 1'b1;
              wb_rd   <= iss.rd;
              wb_data <= '0;
              wb_err  <= 1'b1;
`ifdef HEAP_CMD_STATS_EN
              stat_err <= stat_err + 1'b1;
`endif
              state   <= ST_RETIRE;
            end
          end
        end
        ST_RETIRE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_cmd_issue.sv
// Scoreboard bench for heap_cmd_issue: stimulus pushes expected writebacks and
// issues into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_heap_cmd_issue;
  import heap_cmd_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int HEAP    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic        hp_v;
  logic [2:0]  hp_op;
  logic [31:0] hp_data;
  logic        hp_busy;
  logic        hp_done;
  logic [31:0] hp_rdata;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic [8:0]  occupancy;

  logic        eng_done  = 1'b0;
  logic        late_done = 1'b0;
  bit          engine_en = 1'b1;
  logic [31:0] pop_ret   = '0;

  assign hp_done = eng_done | late_done;

  always #5 clk = ~clk;

  heap_cmd_issue #(
    .FIFO_DEPTH (4),
    .HEAP_SIZE  (HEAP),
    .TIMEOUT    (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_v      (in_v),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_op     (in_op),
    .in_data   (in_data),
    .hp_v      (hp_v),
    .hp_op     (hp_op),
    .hp_data   (hp_data),
    .hp_busy   (hp_busy),
    .hp_done   (hp_done),
    .hp_rdata  (hp_rdata),
    .wb_v      (wb_v),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_err    (wb_err),
    .occupancy (occupancy)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
  } iss_t;

  wb_t  wbq[$];
  iss_t isq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void exp_wb(input logic [4:0] rd, input logic [31:0] data,
                                 input logic err);
    wb_t e;
    e.rd = rd; e.data = data; e.err = err;
    wbq.push_back(e);
  endfunction

  function automatic void exp_iss(input logic [2:0] op, input logic [31:0] data);
    iss_t e;
    e.op = op; e.data = data;
    isq.push_back(e);
  endfunction

  // Monitor: every wb_v / hp_v must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_v) begin
        if (wbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wb: got wb rd=%0d data=0x%0h err=%0b, expected none",
                   wb_rd, wb_data, wb_err);
        end else begin
          wb_t e;
          e = wbq.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
          check("wb_err", 32'(wb_err), 32'(e.err));
        end
      end
      if (hp_v) begin
        if (isq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_issue: got hp_op=%0d hp_data=0x%0h, expected none",
                   hp_op, hp_data);
        end else begin
          iss_t e;
          e = isq.pop_front();
          check("hp_op", 32'(hp_op), 32'(e.op));
          check("hp_data", hp_data, e.data);
        end
      end
    end
  end

  // Heap engine model: completes each issue two cycles after hp_v.
  initial begin
    hp_rdata = '0;
    forever begin
      @(negedge clk);
      if (hp_v && engine_en) begin
        repeat (2) @(negedge clk);
        eng_done = 1'b1;
        hp_rdata = pop_ret;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  task automatic send(input logic [4:0] rd, input logic [2:0] op, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    in_v = 1'b1; in_rd = rd; in_op = op; in_data = data;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_v = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (wbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(wbq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_hp_v"}, 32'(hp_v), 32'd0);
    check({tag, "_hp_op"}, 32'(hp_op), 32'd0);
    check({tag, "_hp_data"}, hp_data, 32'd0);
    check({tag, "_wb_v"}, 32'(wb_v), 32'd0);
    check({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_wb_err"}, 32'(wb_err), 32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    int n;
    int t;
    reset = 1'b1; in_v = 1'b0; in_rd = '0; in_op = '0; in_data = '0; hp_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Pop on an empty heap: rejected one cycle after reaching the head.
    exp_wb(5'd7, 32'd0, 1'b1);
    send(5'd7, OP_POP, 32'd0);
    @(negedge clk);
    check("reject_lat_early", 32'(wb_v), 32'd0);
    @(negedge clk);
    check("reject_lat", 32'(wb_v), 32'd1);
    drain();
    check("occ_after_empty_pop", 32'(occupancy), 32'd0);

    // Push 5, push 9, pop -> 9.
    pop_ret = 32'd9;
    exp_iss(OP_PUSH, 32'd5); exp_wb(5'd3, 32'd1, 1'b0);
    exp_iss(OP_PUSH, 32'd9); exp_wb(5'd4, 32'd2, 1'b0);
    exp_iss(OP_POP,  32'd0); exp_wb(5'd5, 32'd9, 1'b0);
    send(5'd3, OP_PUSH, 32'd5);
    send(5'd4, OP_PUSH, 32'd9);
    send(5'd5, OP_POP,  32'd0);
    drain();
    check("occ_after_basic", 32'(occupancy), 32'd1);

    // Illegal opcode.
    exp_wb(5'd2, 32'd0, 1'b1);
    send(5'd2, 3'd5, 32'hDEAD_BEEF);
    drain();
    check("occ_after_illegal", 32'(occupancy), 32'd1);

    // Busy engine: four commands fill the FIFO, the fifth sees in_ready low.
    hp_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check("fill_in_ready", 32'(in_ready), 32'd1);
        in_v  = 1'b1;
        in_rd = 5'(8 + i);
        in_op = (i == 2) ? OP_POP : OP_PUSH;
        in_data = 32'(10 + i);
      end else begin
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_v = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    check("busy_occ", 32'(occupancy), 32'd1);
    pop_ret = 32'd42;
    exp_iss(OP_PUSH, 32'd10); exp_wb(5'd8,  32'd2,  1'b0);
    exp_iss(OP_PUSH, 32'd11); exp_wb(5'd9,  32'd3,  1'b0);
    exp_iss(OP_POP,  32'd12); exp_wb(5'd10, 32'd42, 1'b0);
    exp_iss(OP_PUSH, 32'd13); exp_wb(5'd11, 32'd3,  1'b0);
    hp_busy = 1'b0;
    drain();
    check("occ_after_busy", 32'(occupancy), 32'd3);

    // Timeout: engine never answers.
    engine_en = 1'b0;
    exp_iss(OP_PUSH, 32'd77); exp_wb(5'd13, 32'd0, 1'b1);
    send(5'd13, OP_PUSH, 32'd77);
    n = 0;
    while (!hp_v && n < 50) begin
      @(negedge clk);
      n++;
    end
    t = 0;
    while (!wb_v && t < TIMEOUT + 20) begin
      @(negedge clk);
      t++;
    end
    check("timeout_latency", 32'(t), 32'(TIMEOUT + 1));
    drain();
    check("occ_after_timeout", 32'(occupancy), 32'd3);
    engine_en = 1'b1;
    exp_iss(OP_PUSH, 32'd78); exp_wb(5'd14, 32'd4, 1'b0);
    send(5'd14, OP_PUSH, 32'd78);
    drain();
    check("occ_full", 32'(occupancy), 32'd4);

    // Push to a full heap is rejected.
    exp_wb(5'd20, 32'd0, 1'b1);
    send(5'd20, OP_PUSH, 32'd99);
    drain();
    check("occ_still_full", 32'(occupancy), 32'd4);

    // Reset mid-WAIT with two commands queued behind the outstanding one.
    engine_en = 1'b0;
    exp_iss(OP_POP, 32'd0);
    send(5'd15, OP_POP, 32'd0);
    n = 0;
    while (isq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    send(5'd16, OP_PUSH, 32'd1);
    send(5'd17, OP_POP, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midwait_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_occ", 32'(occupancy), 32'd0);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("wb_queue_empty", 32'(wbq.size()), 32'd0);
    check("issue_queue_empty", 32'(isq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/heap_cmd_issue.md
Name: heap_cmd_issue

Overview:
- Upstream issue stage for the heap priority-queue custom instruction.
- Accepts push/pop commands from the core-side custom-instruction port into a small command FIFO, and issues them one at a time to the heap engine, respecting its busy flag.
- Tracks heap occupancy so that a push to a full heap or a pop from an empty heap is rejected without being issued.
- Returns one writeback per accepted command, in order, tagged with rd.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- HEAP_SIZE, 256, heap engine capacity; occupancy saturation limit.
- TIMEOUT, 64, maximum number of WAIT cycles before the command is retired with an error.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_v  in  1  command valid from core
- in_ready  out  1  FIFO can accept; a command transfers when in_v && in_ready
- in_rd  in  5  destination register tag
- in_op  in  3  1 = push, 2 = pop, any other value is illegal
- in_data  in  32  push operand (ignored for pop)
- hp_v  out  1  one-cycle issue strobe to the heap engine
- hp_op  out  3  issued opcode
- hp_data  out  32  issued operand
- hp_busy  in  1  heap engine busy; no issue while high
- hp_done  in  1  one-cycle completion pulse from the heap engine
- hp_rdata  in  32  pop result, valid with hp_done
- wb_v  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback tag
- wb_data  out  32  pop: popped value; push: occupancy after the push; error: 0
- wb_err  out  1  writeback is a reject, illegal opcode, or timeout
- occupancy  out  9  current heap element count

Behaviour:
- Reset (asynchronous): FIFO empty, FSM in IDLE, occupancy = 0, timer = 0. All outputs 0 except in_ready, which is 1.
- FIFO:
  - in_ready = !full, combinational from the FIFO count.
  - When full, in_ready stays low even if a dequeue happens in the same cycle.
  - Enqueue and dequeue in the same cycle are allowed when not full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RETIRE.
- IDLE, FIFO non-empty, head is an illegal opcode, or a pop with occupancy == 0, or a push with occupancy == HEAP_SIZE:
  - Dequeue the head and go to RETIRE with err = 1 and data = 0.
  - Nothing is issued to the heap engine.
- IDLE, head is a legal opcode, and !hp_busy: dequeue into the issue register and go to ISSUE.
- IDLE, head is legal but hp_busy is high: stay in IDLE.
- ISSUE:
  - hp_v = 1 for exactly this cycle, with hp_op and hp_data from the issue register.
  - Timer cleared; go to WAIT.
- WAIT:
  - On hp_done: go to RETIRE.
    - Push: occupancy + 1; data = new occupancy.
    - Pop: occupancy - 1; data = hp_rdata.
  - Otherwise the timer increments. When the timer reaches TIMEOUT: go to RETIRE with err = 1, data = 0, occupancy unchanged.
  - An hp_done arriving in the same cycle as the timeout wins (normal completion).
- RETIRE:
  - wb_v = 1 for one cycle with wb_rd, wb_data and wb_err; go to IDLE.
  - Latency from command at the FIFO head to wb_v: 1 cycle on a reject, 3 + engine cycles on an issue.
- Outside ISSUE, hp_v = 0.
- An hp_done received outside WAIT is ignored.
- Writebacks are strictly in acceptance order; at most one command is outstanding.
- occupancy saturates at 0 and at HEAP_SIZE; it is 9 bits, sized for HEAP_SIZE = 256.

Optional Feature:
- HEAP_CMD_STATS_EN defined:
  - Adds three 16-bit wrapping counters: stat_push (completed pushes), stat_pop (completed pops), stat_err (every wb_err writeback).
  - Exposed as output ports stat_push, stat_pop, stat_err; all cleared by reset.
- Undefined: the counters and ports are absent, and all other behaviour is identical.

Decomposition:
- Package heap_cmd_pkg:
  - opcode constants OP_PUSH = 3'd1 and OP_POP = 3'd2;
  - FSM state encodings;
  - command record layout {rd[4:0], op[2:0], data[31:0]}, 40 bits.
- Sub-module heap_cmd_fifo: parameterised synchronous FIFO with full/empty flags and count. The FSM and occupancy logic stay in the top level.

Test Plan:
- Push 5, push 9, pop, each with in_rd = 3, 4, 5, and hp_done returned 2 cycles after each hp_v:
  - wb (3, 1, err 0), wb (4, 2, err 0), wb (5, data = hp_rdata = 9, err 0);
  - occupancy ends at 1.
- Pop immediately after reset, rd = 7: wb_v with rd 7, data 0, err 1, 1 cycle after the command reaches the head; no hp_v; occupancy stays 0.
- Hold hp_busy high and send 5 commands back to back: 4 accepted, then in_ready = 0 for the 5th; no hp_v. Release hp_busy: four issues and four writebacks in order.
- in_op = 3'd5, rd = 2: wb (2, 0, err 1); hp_v never asserted.
- Issue a push and never assert hp_done: wb_err = 1 exactly TIMEOUT cycles after WAIT is entered; occupancy unchanged. The next command then issues normally.
- Assert reset mid-WAIT with 2 commands queued: all outputs return to their reset values at once, the FIFO is empty, and no wb_v is seen for the dropped commands. A late hp_done is ignored.
